// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-requester memory arbiter: FSM states, requester ids
// and the latched memory command payload.
package mem_arb_pkg;

   localparam int unsigned ADDR_W    = 64;
   localparam int unsigned DATA_W    = 64;
   localparam int unsigned IF_DATA_W = 32;
   localparam int unsigned CNT_W     = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef enum logic {
      REQ_IF = 1'b0,
      REQ_DM = 1'b1
   } req_id_e;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } mem_cmd_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the arbiter; slave is the arbiter's view,
// master is the view of the requesters and the memory model around it.
interface mem_arbiter_if;
   import mem_arb_pkg::*;

   logic                 if_req;
   logic [ADDR_W-1:0]    if_addr;
   logic                 if_ack;
   logic [IF_DATA_W-1:0] if_data;
   logic                 if_error;

   logic                 dm_req;
   logic                 dm_we;
   logic [ADDR_W-1:0]    dm_addr;
   logic [DATA_W-1:0]    dm_wdata;
   logic                 dm_ack;
   logic [DATA_W-1:0]    dm_rdata;
   logic                 dm_error;

   logic                 mem_req;
   logic                 mem_we;
   logic [ADDR_W-1:0]    mem_addr;
   logic [DATA_W-1:0]    mem_wdata;
   logic                 mem_ack;
   logic [DATA_W-1:0]    mem_rdata;
   logic                 mem_error;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
             mem_ack, mem_rdata, mem_error,
      output if_ack, if_data, if_error, dm_ack, dm_rdata, dm_error,
             mem_req, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
             mem_ack, mem_rdata, mem_error,
      input  if_ack, if_data, if_error, dm_ack, dm_rdata, dm_error,
             mem_req, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/mem_arbiter_timer.sv
// Outstanding-access timer: counts BUSY cycles and flags the cycle in which
// the count reaches TIMEOUT.
module mem_arb_timer
   import mem_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tc_q, tc_d;

   // tc is high while the counter holds TIMEOUT-1, i.e. the step that reaches TIMEOUT
   always_comb begin
      cnt_d = cnt_q;
      tc_d  = tc_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      tc_d = (cnt_d == LAST);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q <= '0;
         tc_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         tc_q  <= tc_d;
      end
   end

   assign tc_o = tc_q;

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (read
// only) and data memory requesters, with a per-access timeout.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned TIMEOUT     = 16,
   parameter bit          FETCH_FIRST = 1'b1
) (
   input  logic          clk,
   input  logic          reset,
   mem_arbiter_if.slave  bus,
   output logic          busy
);

   state_e               state_q, state_d;
   req_id_e              grant_q, grant_d;
   req_id_e              last_q, last_d;
   req_id_e              win;
   mem_cmd_t             cmd_q, cmd_d;
   logic                 mem_req_q, mem_req_d;
   logic                 busy_q, busy_d;
   logic                 if_ack_q, if_ack_d;
   logic [IF_DATA_W-1:0] if_data_q, if_data_d;
   logic                 if_error_q, if_error_d;
   logic                 dm_ack_q, dm_ack_d;
   logic [DATA_W-1:0]    dm_rdata_q, dm_rdata_d;
   logic                 dm_error_q, dm_error_d;
   logic                 rsp_err;
   logic [DATA_W-1:0]    rsp_data;
   logic                 tmr_clr, tmr_en, tmr_tc;

   mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk   (clk),
      .reset (reset),
      .clr_i (tmr_clr),
      .en_i  (tmr_en),
      .tc_o  (tmr_tc)
   );

   // Next-state, grant and response logic; every output is registered
   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      last_d     = last_q;
      cmd_d      = cmd_q;
      win        = REQ_IF;
      mem_req_d  = 1'b0;
      if_ack_d   = 1'b0;
      if_data_d  = '0;
      if_error_d = 1'b0;
      dm_ack_d   = 1'b0;
      dm_rdata_d = '0;
      dm_error_d = 1'b0;
      rsp_err    = 1'b0;
      rsp_data   = '0;
      tmr_clr    = 1'b0;
      tmr_en     = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.if_req || bus.dm_req) begin
               if (bus.if_req && bus.dm_req) begin
                  win = (last_q == REQ_IF) ? REQ_DM : REQ_IF;
               end else begin
                  win = bus.dm_req ? REQ_DM : REQ_IF;
               end
               grant_d = win;
               last_d  = win;
               if (win == REQ_DM) begin
                  cmd_d.we    = bus.dm_we;
                  cmd_d.addr  = bus.dm_addr;
                  cmd_d.wdata = bus.dm_wdata;
               end else begin
                  cmd_d.we    = 1'b0;
                  cmd_d.addr  = bus.if_addr;
                  cmd_d.wdata = '0;
               end
               mem_req_d = 1'b1;
               tmr_clr   = 1'b1;
               state_d   = BUSY;
            end
         end

         BUSY: begin
            tmr_en = 1'b1;
            // A memory ack in the timeout cycle wins over the timeout
            if (bus.mem_ack || tmr_tc) begin
               state_d  = DONE;
               rsp_err  = bus.mem_ack ? bus.mem_error : 1'b1;
               rsp_data = bus.mem_ack ? bus.mem_rdata : '0;
               if (grant_q == REQ_IF) begin
                  if_ack_d   = 1'b1;
                  if_error_d = rsp_err;
                  if_data_d  = rsp_data[IF_DATA_W-1:0];
               end else begin
                  dm_ack_d   = 1'b1;
                  dm_error_d = rsp_err;
                  dm_rdata_d = cmd_q.we ? '0 : rsp_data;
               end
            end else begin
               mem_req_d = 1'b1;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= IDLE;
         grant_q    <= REQ_IF;
         last_q     <= FETCH_FIRST ? REQ_DM : REQ_IF;
         cmd_q      <= '0;
         mem_req_q  <= 1'b0;
         busy_q     <= 1'b0;
         if_ack_q   <= 1'b0;
         if_data_q  <= '0;
         if_error_q <= 1'b0;
         dm_ack_q   <= 1'b0;
         dm_rdata_q <= '0;
         dm_error_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         last_q     <= last_d;
         cmd_q      <= cmd_d;
         mem_req_q  <= mem_req_d;
         busy_q     <= busy_d;
         if_ack_q   <= if_ack_d;
         if_data_q  <= if_data_d;
         if_error_q <= if_error_d;
         dm_ack_q   <= dm_ack_d;
         dm_rdata_q <= dm_rdata_d;
         dm_error_q <= dm_error_d;
      end
   end

   assign bus.mem_req   = mem_req_q;
   assign bus.mem_we    = cmd_q.we;
   assign bus.mem_addr  = cmd_q.addr;
   assign bus.mem_wdata = cmd_q.wdata;
   assign bus.if_ack    = if_ack_q;
   assign bus.if_data   = if_data_q;
   assign bus.if_error  = if_error_q;
   assign bus.dm_ack    = dm_ack_q;
   assign bus.dm_rdata  = dm_rdata_q;
   assign bus.dm_error  = dm_error_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, reset/stray-ack sequences and
// randomized traffic checked against a rule-level model.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int unsigned TO = 4;

   logic clk = 1'b0;
   logic reset;
   logic busy;

   mem_arbiter_if bus();

   mem_arbiter #(.TIMEOUT(TO), .FETCH_FIRST(1'b1)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus),
      .busy  (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit last_dm;

   typedef struct {
      bit          ifr;
      bit          dmr;
      bit          we;
      bit          drop;
      logic [63:0] ia;
      logic [63:0] da;
      logic [63:0] wd;
      int          lat;
      logic [63:0] rd;
      bit          err;
      bit          exp_dm;
      logic [63:0] exp_data;
      bit          exp_err;
      int          exp_hi;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_quiet(input string nm);
      chk({nm, "_flags"}, 64'({bus.if_ack, bus.dm_ack, bus.if_error, bus.dm_error}), 64'd0);
      chk({nm, "_data"}, 64'(bus.if_data) | bus.dm_rdata, 64'd0);
   endtask

   // Expected outcome from the arbitration, timeout and data-return rules
   function automatic vec_t model(input bit ifr, input bit dmr, input bit we, input bit drop,
                                  input logic [63:0] ia, input logic [63:0] da,
                                  input logic [63:0] wd, input logic [63:0] rd,
                                  input int lat, input bit err);
      vec_t v;
      bit   to;
      v.ifr = ifr; v.dmr = dmr; v.we = we; v.drop = drop;
      v.ia = ia; v.da = da; v.wd = wd; v.rd = rd; v.lat = lat; v.err = err;
      v.exp_dm   = (ifr && dmr) ? !last_dm : dmr;
      to         = (lat >= int'(TO));
      v.exp_hi   = to ? int'(TO) : lat + 1;
      v.exp_err  = to ? 1'b1 : err;
      if (to)             v.exp_data = 64'd0;
      else if (!v.exp_dm) v.exp_data = {32'd0, rd[31:0]};
      else                v.exp_data = we ? 64'd0 : rd;
      return v;
   endfunction

   // One transaction from IDLE through BUSY and DONE back to IDLE
   task automatic do_txn(input vec_t v);
      int hi    = 0;
      bit acked = 1'b0;
      bus.if_req = v.ifr;
      bus.dm_req = v.dmr;
      if (v.ifr) bus.if_addr = v.ia;
      if (v.dmr) begin
         bus.dm_we    = v.we;
         bus.dm_addr  = v.da;
         bus.dm_wdata = v.wd;
      end
      @(negedge clk);
      chk("grant_addr", bus.mem_addr, v.exp_dm ? v.da : v.ia);
      chk("grant_we", 64'(bus.mem_we), 64'(v.exp_dm ? v.we : 1'b0));
      chk("grant_wdata", bus.mem_wdata, v.exp_dm ? v.wd : 64'd0);
      chk("grant_busy", 64'(busy), 64'd1);
      for (int k = 0; k < int'(TO) && !acked; k++) begin
         if (bus.mem_req === 1'b1) hi++;
         chk_quiet("busy_out");
         if (k == 0 && v.drop) begin
            if (v.exp_dm) bus.dm_req = 1'b0;
            else          bus.if_req = 1'b0;
         end
         if (k == v.lat) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = v.rd;
            bus.mem_error = v.err;
            acked         = 1'b1;
         end else begin
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = {$urandom, $urandom};
            bus.mem_error = 1'($urandom);
         end
         @(negedge clk);
      end
      bus.mem_ack   = 1'b0;
      bus.mem_error = 1'b0;
      chk("mem_req_cycles", 64'(hi), 64'(v.exp_hi));
      chk("done_acks", 64'({bus.if_ack, bus.dm_ack}), v.exp_dm ? 64'd1 : 64'd2);
      chk("done_err", 64'({bus.if_error, bus.dm_error}),
          64'({~v.exp_dm & v.exp_err, v.exp_dm & v.exp_err}));
      chk("done_if_data", 64'(bus.if_data), v.exp_dm ? 64'd0 : v.exp_data);
      chk("done_dm_rdata", bus.dm_rdata, v.exp_dm ? v.exp_data : 64'd0);
      chk("done_req_busy", 64'({bus.mem_req, busy}), 64'd1);
      last_dm = v.exp_dm;
      if (v.exp_dm) bus.dm_req = 1'b0;
      else          bus.if_req = 1'b0;
      @(negedge clk);
      chk("idle_req_busy", 64'({bus.mem_req, busy}), 64'd0);
      chk_quiet("idle_out");
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1);
   end

   initial begin
      vec_t        tbl[8];
      vec_t        v;
      bit          pif, pdm, pwe;
      logic [63:0] pia, pda, pwd;

      reset         = 1'b0;
      bus.if_req    = 1'b0;
      bus.if_addr   = '0;
      bus.dm_req    = 1'b0;
      bus.dm_we     = 1'b0;
      bus.dm_addr   = '0;
      bus.dm_wdata  = '0;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      bus.mem_error = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy_req_we", 64'({busy, bus.mem_req, bus.mem_we}), 64'd0);
      chk("rst_mem_bus", bus.mem_addr | bus.mem_wdata, 64'd0);
      chk_quiet("rst_out");
      reset   = 1'b1;
      last_dm = 1'b1;

      //         ifr   dmr   we    drop  ia       da       wd      lat  rd                      err   exp_dm exp_data               exp_err hi
      tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 64'h200, 64'h300, 64'h0,  1,   64'h1111_2222_3333_4444, 1'b0, 1'b0, 64'h3333_4444,          1'b0, 2};
      tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 64'h204, 64'h300, 64'h0,  0,   64'hAAAA_BBBB_CCCC_DDDD, 1'b1, 1'b1, 64'hAAAA_BBBB_CCCC_DDDD, 1'b1, 1};
      tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 64'h204, 64'h308, 64'h77, 3,   64'h0000_0000_9999_8888, 1'b0, 1'b0, 64'h9999_8888,          1'b0, 4};
      tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 64'h40,  64'h308, 64'h77, 0,   64'h1234,                1'b0, 1'b1, 64'h0,                  1'b0, 1};
      tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 64'h40,  64'h0,   64'h0,  0,   64'hDEAD_BEEF_1234_5678, 1'b0, 1'b0, 64'h1234_5678,          1'b0, 1};
      tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 64'h0,   64'h100, 64'h55, 1,   64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 64'h0,                  1'b0, 2};
      tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 64'h80,  64'h0,   64'h0,  255, 64'hCAFE,                1'b0, 1'b0, 64'h0,                  1'b1, 4};
      tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 64'h0,   64'h180, 64'h0,  2,   64'h0123_4567_89AB_CDEF, 1'b1, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b1, 3};
      for (int i = 0; i < 8; i++) do_txn(tbl[i]);

      // Memory ack with no transaction outstanding
      bus.mem_ack   = 1'b1;
      bus.mem_error = 1'b1;
      bus.mem_rdata = 64'hFFFF_0000_FFFF_0000;
      @(negedge clk);
      bus.mem_ack   = 1'b0;
      bus.mem_error = 1'b0;
      chk("stray_ack_busy", 64'({busy, bus.mem_req}), 64'd0);
      chk_quiet("stray_ack");
      @(negedge clk);
      chk_quiet("stray_ack_late");

      // Reset in the middle of an access, with a memory ack arriving at the same edge
      bus.if_req  = 1'b1;
      bus.if_addr = 64'h500;
      @(negedge clk);
      chk("rst_mid_req", 64'(bus.mem_req), 64'd1);
      reset         = 1'b0;
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 64'h1;
      @(negedge clk);
      chk("rst_mid_abort", 64'({busy, bus.mem_req}), 64'd0);
      chk_quiet("rst_mid_out");
      reset       = 1'b1;
      bus.mem_ack = 1'b0;
      bus.if_req  = 1'b0;
      last_dm     = 1'b1;
      @(negedge clk);
      chk("rst_mid_idle", 64'({busy, bus.mem_req}), 64'd0);
      chk_quiet("rst_mid_noack");
      do_txn(model(1'b1, 1'b0, 1'b0, 1'b0, 64'h600, 64'h0, 64'h0,
                   64'h0BAD_F00D_CAFE_D00D, 1, 1'b0));

      // Random traffic: a losing requester keeps its request and operands held
      pif = 1'b0;
      pdm = 1'b0;
      pwe = 1'b0;
      pia = '0;
      pda = '0;
      pwd = '0;
      for (int n = 0; n < 40; n++) begin
         if (!pif && (!pdm || $urandom_range(0, 1) == 1)) begin
            pif = 1'b1;
            pia = {$urandom, $urandom};
         end
         if (!pdm && $urandom_range(0, 1) == 1) begin
            pdm = 1'b1;
            pwe = 1'($urandom);
            pda = {$urandom, $urandom};
            pwd = {$urandom, $urandom};
         end
         v = model(pif, pdm, pwe, ($urandom_range(0, 3) == 0), pia, pda, pwd,
                   {$urandom, $urandom}, int'($urandom_range(0, 5)), 1'($urandom));
         do_txn(v);
         if (v.exp_dm) pdm = 1'b0;
         else          pif = 1'b0;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 16, max cycles a memory access may remain outstanding (legal 1..255).
REQ-002 Parameter: FETCH_FIRST, default 1, selects the requester that wins the first contended arbitration after reset (1 = IF, 0 = DM).
REQ-003 The block SHALL use one clock; reset is synchronous and active-low.
REQ-004 Ports: clk  in  1  clock; reset  in  1  synchronous active-low reset.
REQ-005 Ports: if_req  in  1; if_addr  in  64; if_ack  out  1; if_data  out  32; if_error  out  1  (instruction-fetch requester, read-only).
REQ-006 Ports: dm_req  in  1; dm_we  in  1; dm_addr  in  64; dm_wdata  in  64; dm_ack  out  1; dm_rdata  out  64; dm_error  out  1  (data requester).
REQ-007 Ports: mem_req  out  1; mem_we  out  1; mem_addr  out  64; mem_wdata  out  64; mem_ack  in  1; mem_rdata  in  64; mem_error  in  1  (single shared memory port).
REQ-008 Ports: busy  out  1  (high whenever the state is not IDLE).

Function
REQ-009 Requesters SHALL hold req and operands stable until their ack; ack SHALL be a single-cycle pulse.
REQ-010 States: IDLE, BUSY, DONE; transitions IDLE->BUSY on grant, BUSY->DONE on mem_ack or timeout, DONE->IDLE unconditionally.
REQ-011 In IDLE, a single asserted req SHALL be granted; when both are asserted, the requester not served last SHALL win (round-robin).
REQ-012 At grant, addr/we/wdata of the winner SHALL be latched, with if-grant forcing mem_we=0 and mem_wdata=0; the grant id and last-served id SHALL be registered.
REQ-013 mem_req SHALL be high exactly while in BUSY, with mem_addr/mem_we/mem_wdata driven from the latched values; it SHALL go high the cycle after the req was sampled in IDLE.
REQ-014 mem_ack sampled high in BUSY at cycle c SHALL produce the granted requester's ack at c+1 (DONE), with data and error registered from mem_rdata/mem_error at c.
REQ-015 if_data SHALL equal mem_rdata[31:0] as latched; dm_rdata SHALL equal the full 64 bits; for writes, dm_rdata SHALL be 0.
REQ-016 A cycle counter SHALL clear on entering BUSY and increment each BUSY cycle; when it reaches TIMEOUT without mem_ack, the block SHALL enter DONE with ack=1, error=1, data=0.
REQ-017 mem_ack and timeout in the same cycle SHALL be treated as mem_ack (no error unless mem_error).
REQ-018 mem_ack outside BUSY SHALL be ignored.
REQ-019 No arbitration SHALL occur in BUSY or DONE; a held req is re-evaluated only in IDLE, so back-to-back grants are at least 3 cycles apart.
REQ-020 A req dropped while its transaction is in flight SHALL NOT abort it; the ack is still issued.
REQ-021 Acks, data and error outputs SHALL be 0 in every cycle other than DONE.

Reset
REQ-022 While reset is 0 at a clock edge: state=IDLE, counter=0, all acks/errors/data/mem_* outputs=0, busy=0, last-served = DM if FETCH_FIRST=1 else IF.
REQ-023 Reset asserted mid-transaction SHALL abandon it: mem_req low the next cycle, no ack issued.

Structure
REQ-024 Shared package mem_arb_pkg SHALL hold the state enum (IDLE/BUSY/DONE) and requester-id enum (REQ_IF/REQ_DM).
REQ-025 One sub-module, mem_arb_timer (8-bit counter with clear, enable and terminal-count at TIMEOUT), SHALL implement REQ-016.

Verification
REQ-026 if_req, if_addr=0x40, mem_ack one cycle after mem_req with mem_rdata=0xDEAD_BEEF_1234_5678 -> mem_addr=0x40, mem_we=0; if_ack one cycle, if_data=0x12345678, if_error=0.
REQ-027 if_req and dm_req rise together after reset, FETCH_FIRST=1, both held -> IF served first, DM next; then two more contended rounds alternate IF, DM.
REQ-028 dm_req, dm_we=1, dm_addr=0x100, dm_wdata=0x55 -> mem_we=1, mem_wdata=0x55, dm_ack pulse, dm_rdata=0.
REQ-029 mem_ack never asserted, TIMEOUT=4 -> mem_req high 4 cycles, then ack with error=1, data=0; busy returns to 0 two cycles later.
REQ-030 reset driven to 0 during BUSY, then mem_ack asserted -> mem_req 0 next cycle, no ack, state IDLE; a new if_req is served normally.
